// File: rtl/wb_pkg.sv
// Shared defaults and arbiter state type for the register-file writeback controller.
package wb_pkg;
  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic {
    ST_NORMAL    = 1'b0,
    ST_FORCE_MEM = 1'b1
  } wb_state_e;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Writeback source bundle: unbuffered ALU result plus the mem/MDU valid/ready channel.
interface reg_wb_ctrl_if
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
);
  logic              alu_wb_valid;
  logic [REG_AW-1:0] alu_wb_rd;
  logic [XLEN-1:0]   alu_wb_data;
  logic              mem_wb_valid;
  logic              mem_wb_ready;
  logic [REG_AW-1:0] mem_wb_rd;
  logic [XLEN-1:0]   mem_wb_data;

  modport master (
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  mem_wb_ready
  );

  modport slave (
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  mem_wb_valid, mem_wb_rd, mem_wb_data,
    output mem_wb_ready
  );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering mem/MDU writebacks as {rd, data}.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Pointer and occupancy tracking; reset discards all contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= din;
  end

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rptr];
endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port controller: ALU-priority arbiter with bounded
// starvation of the buffered mem/MDU source, plus pending-destination scoreboard.
module reg_wb_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_DEFER  = 4
) (
  input  logic              clk,
  input  logic              rst,
  reg_wb_ctrl_if.slave      wb,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              stall_req,
  output logic [REG_AW-1:0] Addr3,
  output logic [XLEN-1:0]   wd3,
  output logic              we3
);
  localparam int unsigned NREG  = 2 ** REG_AW;
  localparam int unsigned ENT_W = REG_AW + XLEN;
  localparam int unsigned DW    = (MAX_DEFER > 1) ? $clog2(MAX_DEFER) : 1;
  localparam logic [DW-1:0] DEFER_LIM = DW'(MAX_DEFER - 1);

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ENT_W-1:0]  w_head;
  logic [REG_AW-1:0] w_head_rd;
  logic [XLEN-1:0]   w_head_data;

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic [DW-1:0]     r_defer;
  logic [DW-1:0]     w_defer_nxt;
  logic              w_win;
  logic [REG_AW-1:0] w_win_rd;
  logic [XLEN-1:0]   w_win_data;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic              r_we3;
  logic [REG_AW-1:0] r_addr3;
  logic [XLEN-1:0]   r_wd3;

  assign w_push          = wb.mem_wb_valid && !w_full;
  assign wb.mem_wb_ready = !w_full;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({wb.mem_wb_rd, wb.mem_wb_data}),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign w_head_rd   = w_head[ENT_W-1 -: REG_AW];
  assign w_head_data = w_head[XLEN-1:0];

  // Arbitration: pick this cycle's winner and the next FSM/defer state.
  always_comb begin
    w_pop       = 1'b0;
    w_win       = 1'b0;
    w_win_rd    = '0;
    w_win_data  = '0;
    w_state_nxt = r_state;
    w_defer_nxt = r_defer;
    case (r_state)
      ST_NORMAL: begin
        if (wb.alu_wb_valid) begin
          w_win      = 1'b1;
          w_win_rd   = wb.alu_wb_rd;
          w_win_data = wb.alu_wb_data;
          if (!w_empty) begin
            if (r_defer == DEFER_LIM) w_state_nxt = ST_FORCE_MEM;
            else                      w_defer_nxt = r_defer + 1'b1;
          end
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_win       = 1'b1;
          w_win_rd    = w_head_rd;
          w_win_data  = w_head_data;
          w_defer_nxt = '0;
        end
      end
      ST_FORCE_MEM: begin
        w_pop       = !w_empty;
        w_win       = !w_empty;
        w_win_rd    = w_head_rd;
        w_win_data  = w_head_data;
        w_defer_nxt = '0;
        w_state_nxt = ST_NORMAL;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // Scoreboard update: clear on FIFO writeback, then set on issue so a same-cycle set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head_rd] = 1'b0;
    if (issue_valid) w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Arbiter FSM, scoreboard and registered write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_NORMAL;
      r_defer <= '0;
      r_busy  <= '0;
      r_we3   <= 1'b0;
      r_addr3 <= '0;
      r_wd3   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_defer <= w_defer_nxt;
      r_busy  <= w_busy_nxt;
      r_we3   <= w_win && (w_win_rd != '0);
      if (w_win && (w_win_rd != '0)) begin
        r_addr3 <= w_win_rd;
        r_wd3   <= w_win_data;
      end
    end
  end

  assign stall_req = (r_state == ST_FORCE_MEM);
  assign rs1_busy  = r_busy[rs1];
  assign rs2_busy  = r_busy[rs2];
  assign we3       = r_we3;
  assign Addr3     = r_addr3;
  assign wd3       = r_wd3;
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model of the writeback rules.
module tb_reg_wb_ctrl;
  localparam int unsigned MAXD  = 4;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        stall_req;
  logic [4:0]  Addr3;
  logic [31:0] wd3;
  logic        we3;

  int n_checks = 0;
  int n_pass   = 0;

  reg_wb_ctrl_if #(.XLEN(32), .REG_AW(5)) wbif ();

  reg_wb_ctrl #(
    .XLEN       (32),
    .REG_AW     (5),
    .FIFO_DEPTH (DEPTH),
    .MAX_DEFER  (MAXD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wbif),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .stall_req   (stall_req),
    .Addr3       (Addr3),
    .wd3         (wd3),
    .we3         (we3)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wbif.alu_wb_valid = 1'b0;
    wbif.alu_wb_rd    = '0;
    wbif.alu_wb_data  = '0;
    wbif.mem_wb_valid = 1'b0;
    wbif.mem_wb_rd    = '0;
    wbif.mem_wb_data  = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wbif.alu_wb_valid = 1'b1; wbif.alu_wb_rd = 5'd1; wbif.alu_wb_data = 32'h1;
    issue_valid = 1'b1; issue_rd = 5'd5;
    wbif.mem_wb_valid = 1'b1; wbif.mem_wb_rd = 5'd5; wbif.mem_wb_data = 32'hA5A5;
    @(negedge clk);
    issue_valid = 1'b0;
    wbif.mem_wb_rd = 5'd6; wbif.mem_wb_data = 32'hB6B6;
    @(negedge clk);
    wbif.mem_wb_valid = 1'b0; rs1 = 5'd5;
    #1;
    n_checks++; if (wbif.mem_wb_ready !== 1'b0) $display("FAIL rst_prefill_full: ready=%0b want 0", wbif.mem_wb_ready); else n_pass++;
    n_checks++; if (rs1_busy !== 1'b1) $display("FAIL rst_prefill_busy: rs1_busy=%0b want 1", rs1_busy); else n_pass++;
    rst = 1'b0;
    idle();
    rs1 = 5'd5;
    @(negedge clk);
    n_checks++; if (we3 !== 1'b0) $display("FAIL rst_we3: we3=%0b want 0", we3); else n_pass++;
    n_checks++; if (Addr3 !== 5'd0) $display("FAIL rst_addr3: Addr3=%0d want 0", Addr3); else n_pass++;
    n_checks++; if (wd3 !== 32'd0) $display("FAIL rst_wd3: wd3=%0h want 0", wd3); else n_pass++;
    n_checks++; if (wbif.mem_wb_ready !== 1'b1) $display("FAIL rst_ready: ready=%0b want 1", wbif.mem_wb_ready); else n_pass++;
    n_checks++; if (rs1_busy !== 1'b0) $display("FAIL rst_busy: rs1_busy=%0b want 0", rs1_busy); else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (we3 !== 1'b0) $display("FAIL rst_no_stale: cycle %0d we3=%0b Addr3=%0d want we3 0", i, we3, Addr3); else n_pass++;
    end
    n_checks++; if (stall_req !== 1'b0) $display("FAIL rst_stall: stall_req=%0b want 0", stall_req); else n_pass++;
    n_checks++; if (rs1_busy !== 1'b0) $display("FAIL rst_busy_after: rs1_busy=%0b want 0", rs1_busy); else n_pass++;
  endtask

  task automatic test_alu_single();
    idle();
    wbif.alu_wb_valid = 1'b1; wbif.alu_wb_rd = 5'd3; wbif.alu_wb_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (we3 !== 1'b1) $display("FAIL alu_we3: we3=%0b want 1", we3); else n_pass++;
    n_checks++; if (Addr3 !== 5'd3) $display("FAIL alu_addr3: Addr3=%0d want 3", Addr3); else n_pass++;
    n_checks++; if (wd3 !== 32'hDEADBEEF) $display("FAIL alu_wd3: wd3=%0h want deadbeef", wd3); else n_pass++;
    wbif.alu_wb_rd = 5'd0; wbif.alu_wb_data = 32'h12345678;
    @(negedge clk);
    n_checks++; if (we3 !== 1'b0) $display("FAIL alu_x0: we3=%0b want 0", we3); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_forced_drain();
    idle();
    wbif.alu_wb_valid = 1'b1; wbif.alu_wb_rd = 5'd2; wbif.alu_wb_data = 32'hAAAA0002;
    wbif.mem_wb_valid = 1'b1; wbif.mem_wb_rd = 5'd7; wbif.mem_wb_data = 32'h11;
    @(negedge clk);
    wbif.mem_wb_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (stall_req !== 1'b0) $display("FAIL drain_nostall: cycle %0d stall_req=%0b want 0", i, stall_req); else n_pass++;
      n_checks++; if (we3 !== 1'b1 || Addr3 !== 5'd2) $display("FAIL drain_alu: cycle %0d we3=%0b Addr3=%0d want 1/2", i, we3, Addr3); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (stall_req !== 1'b1) $display("FAIL drain_stall: stall_req=%0b want 1", stall_req); else n_pass++;
    @(negedge clk);
    n_checks++; if (we3 !== 1'b1 || Addr3 !== 5'd7 || wd3 !== 32'h11) $display("FAIL drain_mem: we3=%0b Addr3=%0d wd3=%0h want 1/7/11", we3, Addr3, wd3); else n_pass++;
    n_checks++; if (stall_req !== 1'b0) $display("FAIL drain_release: stall_req=%0b want 0", stall_req); else n_pass++;
    @(negedge clk);
    n_checks++; if (we3 !== 1'b1 || Addr3 !== 5'd2 || wd3 !== 32'hAAAA0002) $display("FAIL drain_resume: we3=%0b Addr3=%0d wd3=%0h want 1/2/aaaa0002", we3, Addr3, wd3); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    ent_t got[$];
    ent_t e;
    bit   xfer;
    bit   done_push;
    logic [4:0]  exp_rd;
    logic [31:0] exp_d;
    idle();
    wbif.alu_wb_valid = 1'b1; wbif.alu_wb_rd = 5'd4; wbif.alu_wb_data = 32'h4444;
    wbif.mem_wb_valid = 1'b1; wbif.mem_wb_rd = 5'd10; wbif.mem_wb_data = 32'h100;
    #1;
    n_checks++; if (wbif.mem_wb_ready !== 1'b1) $display("FAIL full_ready0: ready=%0b want 1", wbif.mem_wb_ready); else n_pass++;
    @(negedge clk);
    wbif.mem_wb_rd = 5'd11; wbif.mem_wb_data = 32'h101;
    @(negedge clk);
    wbif.mem_wb_rd = 5'd12; wbif.mem_wb_data = 32'h102;
    #1;
    n_checks++; if (wbif.mem_wb_ready !== 1'b0) $display("FAIL full_ready_low: ready=%0b want 0", wbif.mem_wb_ready); else n_pass++;
    xfer = 1'b0;
    done_push = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (we3 === 1'b1 && Addr3 >= 5'd10 && Addr3 <= 5'd12) begin
        e.rd = Addr3; e.data = wd3;
        got.push_back(e);
      end
      if (xfer) begin
        wbif.mem_wb_valid = 1'b0;
        xfer = 1'b0;
        done_push = 1'b1;
      end else if (!done_push) begin
        #1;
        if (wbif.mem_wb_ready === 1'b1) xfer = 1'b1;
      end
    end
    n_checks++; if (got.size() != 3) $display("FAIL full_count: writes=%0d want 3", got.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp_rd = 5'(10 + i);
      exp_d  = 32'h100 + 32'(i);
      n_checks++;
      if (i >= got.size()) $display("FAIL full_order: entry %0d missing want rd=%0d", i, exp_rd);
      else if (got[i].rd !== exp_rd || got[i].data !== exp_d) $display("FAIL full_order: entry %0d got rd=%0d data=%0h want rd=%0d data=%0h", i, got[i].rd, got[i].data, exp_rd, exp_d);
      else n_pass++;
    end
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_scoreboard();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd9;
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) $display("FAIL sb_set_rs1: rs1_busy=%0b want 1", rs1_busy); else n_pass++;
    n_checks++; if (rs2_busy !== 1'b1) $display("FAIL sb_set_rs2: rs2_busy=%0b want 1", rs2_busy); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (rs1_busy !== 1'b1) $display("FAIL sb_hold: rs1_busy=%0b want 1", rs1_busy); else n_pass++;
    wbif.mem_wb_valid = 1'b1; wbif.mem_wb_rd = 5'd9; wbif.mem_wb_data = 32'h99;
    @(negedge clk);
    wbif.mem_wb_valid = 1'b0;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) $display("FAIL sb_before_win: rs1_busy=%0b want 1", rs1_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (we3 !== 1'b1 || Addr3 !== 5'd9 || wd3 !== 32'h99) $display("FAIL sb_write: we3=%0b Addr3=%0d wd3=%0h want 1/9/99", we3, Addr3, wd3); else n_pass++;
    n_checks++; if (rs1_busy !== 1'b0) $display("FAIL sb_cleared: rs1_busy=%0b want 0", rs1_busy); else n_pass++;
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    issue_valid = 1'b0;
    wbif.mem_wb_valid = 1'b1; wbif.mem_wb_rd = 5'd9; wbif.mem_wb_data = 32'h98;
    @(negedge clk);
    wbif.mem_wb_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    issue_valid = 1'b0;
    n_checks++; if (we3 !== 1'b1 || Addr3 !== 5'd9 || wd3 !== 32'h98) $display("FAIL sb_clear_write: we3=%0b Addr3=%0d wd3=%0h want 1/9/98", we3, Addr3, wd3); else n_pass++;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) $display("FAIL sb_set_wins: rs1_busy=%0b want 1", rs1_busy); else n_pass++;
    wbif.mem_wb_valid = 1'b1; wbif.mem_wb_rd = 5'd9; wbif.mem_wb_data = 32'h97;
    @(negedge clk);
    wbif.mem_wb_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (rs1_busy !== 1'b0) $display("FAIL sb_final_clear: rs1_busy=%0b want 0", rs1_busy); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_x0_mem();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0;
    wbif.mem_wb_valid = 1'b1; wbif.mem_wb_rd = 5'd0; wbif.mem_wb_data = 32'h55;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (rs1_busy !== 1'b0) $display("FAIL x0_busy: rs1_busy=%0b want 0", rs1_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (we3 !== 1'b0) $display("FAIL x0_no_we: we3=%0b want 0", we3); else n_pass++;
    wbif.mem_wb_valid = 1'b1; wbif.mem_wb_rd = 5'd13; wbif.mem_wb_data = 32'h13;
    #1;
    n_checks++; if (wbif.mem_wb_ready !== 1'b1) $display("FAIL x0_ready: ready=%0b want 1", wbif.mem_wb_ready); else n_pass++;
    @(negedge clk);
    wbif.mem_wb_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (we3 !== 1'b1 || Addr3 !== 5'd13 || wd3 !== 32'h13) $display("FAIL x0_popped: we3=%0b Addr3=%0d wd3=%0h want 1/13/13", we3, Addr3, wd3); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_random();
    ent_t        mq[$];
    ent_t        hd;
    ent_t        ne;
    bit [31:0]   m_busy;
    int          losses;
    bit          m_forcing;
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    bit          win;
    bit          pop;
    bit          push;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [4:0]  cand;
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_busy = '0; losses = 0; m_forcing = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      n_checks++; if (we3 !== exp_we) $display("FAIL rnd_we3: cycle %0d we3=%0b want %0b", cyc, we3, exp_we); else n_pass++;
      if (exp_we) begin
        n_checks++; if (Addr3 !== exp_addr || wd3 !== exp_data) $display("FAIL rnd_write: cycle %0d Addr3=%0d wd3=%0h want %0d/%0h", cyc, Addr3, wd3, exp_addr, exp_data); else n_pass++;
      end
      n_checks++; if (stall_req !== m_forcing) $display("FAIL rnd_stall: cycle %0d stall_req=%0b want %0b", cyc, stall_req, m_forcing); else n_pass++;
      if (!m_forcing) begin
        wbif.alu_wb_valid = ($urandom_range(0, 3) != 0);
        wbif.alu_wb_rd    = 5'($urandom_range(0, 31));
        wbif.alu_wb_data  = $urandom;
      end
      wbif.mem_wb_valid = $urandom_range(0, 1) == 1;
      cand = 5'($urandom_range(0, 31));
      for (int t = 0; t < 4 && !m_busy[cand]; t++) cand = 5'($urandom_range(0, 31));
      wbif.mem_wb_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : cand;
      wbif.mem_wb_data = $urandom;
      cand = 5'($urandom_range(0, 31));
      issue_valid = ($urandom_range(0, 3) == 0) && !m_busy[cand];
      issue_rd    = cand;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      #1;
      n_checks++; if (wbif.mem_wb_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_ready: cycle %0d ready=%0b want %0b", cyc, wbif.mem_wb_ready, (mq.size() < DEPTH)); else n_pass++;
      n_checks++; if (rs1_busy !== m_busy[rs1]) $display("FAIL rnd_rs1: cycle %0d rs1=%0d busy=%0b want %0b", cyc, rs1, rs1_busy, m_busy[rs1]); else n_pass++;
      n_checks++; if (rs2_busy !== m_busy[rs2]) $display("FAIL rnd_rs2: cycle %0d rs2=%0d busy=%0b want %0b", cyc, rs2, rs2_busy, m_busy[rs2]); else n_pass++;
      push = wbif.mem_wb_valid && (mq.size() < DEPTH);
      win = 1'b0; pop = 1'b0; wrd = '0; wdat = '0; hd.rd = '0; hd.data = '0;
      if (m_forcing) begin
        hd = mq.pop_front();
        pop = 1'b1; win = 1'b1; wrd = hd.rd; wdat = hd.data;
        m_forcing = 1'b0; losses = 0;
      end else if (wbif.alu_wb_valid) begin
        win = 1'b1; wrd = wbif.alu_wb_rd; wdat = wbif.alu_wb_data;
        if (mq.size() > 0) begin
          losses++;
          if (losses == MAXD) m_forcing = 1'b1;
        end
      end else if (mq.size() > 0) begin
        hd = mq.pop_front();
        pop = 1'b1; win = 1'b1; wrd = hd.rd; wdat = hd.data;
        losses = 0;
      end
      exp_we = win && (wrd != 5'd0);
      if (exp_we) begin
        exp_addr = wrd;
        exp_data = wdat;
      end
      if (pop) m_busy[hd.rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      if (push) begin
        ne.rd = wbif.mem_wb_rd; ne.data = wbif.mem_wb_data;
        mq.push_back(ne);
      end
    end
    idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_alu_single();
    test_forced_drain();
    test_fifo_full();
    test_scoreboard();
    test_x0_mem();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
